// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_master
//  Description : Single-outstanding AXI-Lite style master. Accepts one user
//                command at a time, runs the write (address + data + response)
//                or read (address + data) handshakes and reports completion
//                with a one-cycle rsp_valid pulse.
//                Optional response watchdog: define AXI_LITE_MASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // user command
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
  // user completion
  output logic                      rsp_valid,
  output logic                      rsp_write,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  // write-address channel
  output logic                      waddr_valid,
  input  logic                      waddr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] waddr,
  // write-data channel
  output logic                      wdata_valid,
  input  logic                      wdata_ready,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  // write-response channel
  input  logic [1:0]                bresp,
  input  logic                      bresp_valid,
  output logic                      bresp_ready,
  // read-address channel
  output logic                      raddr_valid,
  input  logic                      raddr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] raddr,
  // read-data channel
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rdata_valid,
  output logic                      rdata_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic                      tmo_hit;

  // Address/data come straight from the captured command so they cannot
  // change while a valid is pending.
  assign waddr = addr_q;
  assign raddr = addr_q;
  assign wdata = wdata_q;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_active;

  assign tmo_active = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_RESP);
  // Limit is reached after TIMEOUT_CYCLES cycles spent in the bus phases.
  assign tmo_hit    = tmo_active && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog next-state: cleared while idle, counts during bus phases.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_active) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // Watchdog compiled out: the parameter is kept so instantiations stay
  // identical between builds; nothing consumes it.
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
`endif

  // State and captured-command registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and output decode; outputs depend on registered state only.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    cmd_ready   = 1'b0;
    waddr_valid = 1'b0;
    wdata_valid = 1'b0;
    bresp_ready = 1'b0;
    raddr_valid = 1'b0;
    rdata_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_write   = 1'b0;
    rsp_rdata   = '0;
    rsp_resp    = 2'b00;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // Each channel drops its valid independently after its handshake.
        waddr_valid = !aw_done_q;
        wdata_valid = !w_done_q;
        if (waddr_ready && !aw_done_q) aw_done_d = 1'b1;
        if (wdata_ready && !w_done_q)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)     state_d   = WR_RESP;
      end
      WR_RESP: begin
        bresp_ready = 1'b1;
        if (bresp_valid) begin
          resp_d  = bresp;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RD_REQ: begin
        raddr_valid = 1'b1;
        if (raddr_ready) state_d = RD_RESP;
      end
      RD_RESP: begin
        rdata_ready = 1'b1;
        if (rdata_valid) begin
          rdata_d = rdata;
          resp_d  = rresp;
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_write = write_q;
        rsp_rdata = rdata_q;
        rsp_resp  = resp_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog expiry overrides whatever the bus phase was doing.
    if (tmo_hit) begin
      state_d = DONE;
      resp_d  = 2'b11;
      rdata_d = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_master
//  Description : Self-checking bench for axi_lite_master with a simple slave
//                model and a response scoreboard. Compiles the watchdog test
//                when AXI_LITE_MASTER_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        waddr_valid, waddr_ready = 1'b0;
  logic [31:0] waddr;
  logic        wdata_valid, wdata_ready = 1'b0;
  logic [31:0] wdata;
  logic [1:0]  bresp = 2'b00;
  logic        bresp_valid = 1'b0, bresp_ready;
  logic        raddr_valid, raddr_ready = 1'b0;
  logic [31:0] raddr;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rdata_valid = 1'b0, rdata_ready;

  axi_lite_master #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .bresp(bresp), .bresp_valid(bresp_valid), .bresp_ready(bresp_ready),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
    .rdata(rdata), .rresp(rresp), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sbq[$];

  // slave configuration
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_never = 1'b0, r_never = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  // monitor results
  int rsp_cnt = 0, rsp_cyc = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0;

  // Bus process: monitor first (sees readies as they were at the last edge),
  // then the slave model updates its drives for the next edge.
  initial begin
    int aw_n, w_n, b_n, ar_n, r_n;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_wa, p_wd, p_ra;
    exp_t e;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_wa = '0; p_wd = '0; p_ra = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (waddr_valid) aw_hi++;
        if (wdata_valid) w_hi++;
        if (raddr_valid) ar_hi++;
        if (p_awv && !p_awr) check("aw_hold", {waddr_valid, waddr}, {1'b1, p_wa});
        if (p_wv  && !p_wr)  check("w_hold",  {wdata_valid, wdata}, {1'b1, p_wd});
        if (p_arv && !p_arr) check("ar_hold", {raddr_valid, raddr}, {1'b1, p_ra});
        if (rsp_valid) begin
          rsp_cnt++;
          rsp_cyc = cyc;
          if (sbq.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("rsp_write", rsp_write, e.wr);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp",  rsp_resp,  e.resp);
          end
        end
      end
      // slave model
      if (waddr_valid) begin waddr_ready = (aw_n >= aw_dly); aw_n++; end
      else begin waddr_ready = 1'b0; aw_n = 0; end
      if (wdata_valid) begin wdata_ready = (w_n >= w_dly); w_n++; end
      else begin wdata_ready = 1'b0; w_n = 0; end
      if (raddr_valid) begin raddr_ready = (ar_n >= ar_dly); ar_n++; end
      else begin raddr_ready = 1'b0; ar_n = 0; end
      if (bresp_ready && !b_never) begin bresp_valid = (b_n >= b_dly); b_n++; end
      else begin bresp_valid = 1'b0; b_n = 0; end
      if (rdata_ready && !r_never) begin rdata_valid = (r_n >= r_dly); r_n++; end
      else begin rdata_valid = 1'b0; r_n = 0; end
      bresp = cfg_bresp;
      rresp = cfg_rresp;
      rdata = cfg_rdata;
      p_awv = waddr_valid && rst_n; p_awr = waddr_ready; p_wa = waddr;
      p_wv  = wdata_valid && rst_n; p_wr  = wdata_ready; p_wd = wdata;
      p_arv = raddr_valid && rst_n; p_arr = raddr_ready; p_ra = raddr;
    end
  end

  // Issue one command, then check request phase, latency, beat counts and
  // that exactly one completion occurred. elat/ebeats <= 0 skips that check.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] erdata,
                         input logic [1:0] eresp, input int elat, input int eaw, input int ew);
    exp_t e;
    int   n, acc, base;
    e.wr = wr; e.rdata = wr ? 32'h0 : erdata; e.resp = eresp;
    sbq.push_back(e);
    base = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      void'(sbq.pop_back());
      return;
    end
    acc = cyc; aw_hi = 0; w_hi = 0; ar_hi = 0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~data;
    check({tag, "_cmd_ready_busy"}, cmd_ready, 0);
    if (wr) begin
      check({tag, "_wvalids_c1"}, {waddr_valid, wdata_valid}, 2'b11);
      check({tag, "_waddr"}, waddr, addr);
      check({tag, "_wdata"}, wdata, data);
    end else begin
      check({tag, "_rvalid_c1"}, raddr_valid, 1'b1);
      check({tag, "_raddr"}, raddr, addr);
    end
    n = 0;
    while (rsp_cnt == base && n < 300) begin @(negedge clk); n++; end
    if (rsp_cnt == base) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      return;
    end
    if (elat > 0) check({tag, "_latency"}, rsp_cyc - acc, elat);
    if (wr) begin
      if (eaw > 0) check({tag, "_aw_cycles"}, aw_hi, eaw);
      if (ew > 0)  check({tag, "_w_cycles"}, w_hi, ew);
    end else if (eaw > 0) begin
      check({tag, "_ar_cycles"}, ar_hi, eaw);
    end
    repeat (3) @(negedge clk);
    check({tag, "_single_rsp"}, rsp_cnt - base, 1);
    check({tag, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, base;
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl_outs", {waddr_valid, wdata_valid, raddr_valid, bresp_ready, rdata_ready, rsp_valid}, 6'b0);
    check("rst_rsp_data", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    check("rst_addr", {waddr, raddr}, 64'h0);
    check("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);

    // minimum-latency write, always-ready slave
    run_cmd("wr_fast", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 3, 1, 1);

    // waddr_ready delayed 3 cycles, wdata immediate
    aw_dly = 3;
    run_cmd("wr_awslow", 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 2'b00, 6, 4, 1);
    aw_dly = 0;

    // wdata late, bresp late, SLVERR response
    w_dly = 2; b_dly = 2; cfg_bresp = 2'b10;
    run_cmd("wr_wslow", 1'b1, 32'h18, 32'h0BADC0DE, 32'h0, 2'b10, 7, 1, 3);
    w_dly = 0; b_dly = 0; cfg_bresp = 2'b00;

    // read with immediate slave
    cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
    run_cmd("rd_fast", 1'b0, 32'h20, 32'h0, 32'h12345678, 2'b10, 3, 1, 0);

    // read with delayed address and data
    ar_dly = 1; r_dly = 2; cfg_rdata = 32'hA5A55A5A; cfg_rresp = 2'b01;
    run_cmd("rd_slow", 1'b0, 32'h24, 32'h0, 32'hA5A55A5A, 2'b01, 6, 2, 0);
    ar_dly = 0; r_dly = 0;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // write response never arrives: watchdog completes with 2'b11
    b_never = 1'b1;
    run_cmd("wr_tmo", 1'b1, 32'h30, 32'h11112222, 32'h0, 2'b11, 17, 1, 1);
    b_never = 1'b0;
`endif

    // reset while waiting in RD_RESP: aborted, no completion
    r_never = 1'b1;
    base = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rdata_ready && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_in_rd_resp", rdata_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {waddr_valid, wdata_valid, raddr_valid, bresp_ready, rdata_ready, rsp_valid}, 6'b0);
    rst_n = 1'b1;
    r_never = 1'b0;
    @(negedge clk);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_no_rsp", rsp_cnt - base, 0);

    // recovery after abort
    cfg_rdata = 32'h0F0F00FF; cfg_rresp = 2'b00;
    run_cmd("rd_after_rst", 1'b0, 32'h44, 32'h0, 32'h0F0F00FF, 2'b00, 3, 1, 0);

    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
